// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared state encoding and constants for the instruction fetch stage.
package ifetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DISCARD, HOLD} ifetch_state_e;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: memory handshake, redirect, and IF/ID signals of the fetch stage.
// IFETCH_STATS_EN adds the FetchCount/RedirectCount counters.
interface instruction_fetch_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic [31:0] IMemData;
    logic        PCSrc;
    logic [31:0] BranchTarget;
    logic        Stall;
    logic [31:0] Instruction;
    logic [31:0] InstrPC;
    logic        InstrValid;
`ifdef IFETCH_STATS_EN
    logic [31:0] FetchCount;
    logic [31:0] RedirectCount;
`endif
    modport master (
        input  IMemReady, IMemData, PCSrc, BranchTarget, Stall,
`ifdef IFETCH_STATS_EN
        output FetchCount, RedirectCount,
`endif
        output IMemReq, IMemAddr, Instruction, InstrPC, InstrValid
    );
    modport slave (
        output IMemReady, IMemData, PCSrc, BranchTarget, Stall,
`ifdef IFETCH_STATS_EN
        input  FetchCount, RedirectCount,
`endif
        input  IMemReq, IMemAddr, Instruction, InstrPC, InstrValid
    );
endinterface

// File: rtl/ifetch_skid_buf.sv
// ifetch_skid_buf: one-entry {word, PC, valid} holding register; clear wins over load, load over drain.
module ifetch_skid_buf
    import ifetch_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] word_in,
    input  logic [31:0] pc_in,
    output logic [31:0] word_q,
    output logic [31:0] pc_q,
    output logic        valid_q
);
    logic [31:0] word_d, pc_d;
    logic        valid_d;

    always_comb begin
        word_d  = load ? word_in : word_q;
        pc_d    = load ? pc_in : pc_q;
        valid_d = clear ? 1'b0 : load ? 1'b1 : drain ? 1'b0 : valid_q;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            word_q  <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC/request FSM feeding a registered IF/ID slot, with skid buffer and redirect.
// IFETCH_STATS_EN adds FetchCount/RedirectCount.
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input logic                 Clk,
    input logic                 Rst,
    instruction_fetch_if.master bus
);
    localparam logic [31:0] RESET_PC_A = RESET_PC & ~32'h3;

    ifetch_state_e state_q, state_d;
    logic [31:0]   pc_q, pc_d, addr_q, addr_d;
    logic [31:0]   instr_q, instr_d, ipc_q, ipc_d;
    logic          req_q, req_d, valid_q, valid_d;
    logic          load_mem, load_skid, skid_load;
    logic [31:0]   skid_word, skid_pc;
    logic          skid_valid;

    ifetch_skid_buf u_skid (
        .Clk     (Clk),
        .Rst     (Rst),
        .load    (skid_load),
        .drain   (load_skid),
        .clear   (bus.PCSrc),
        .word_in (bus.IMemData),
        .pc_in   (pc_q),
        .word_q  (skid_word),
        .pc_q    (skid_pc),
        .valid_q (skid_valid)
    );

    always_comb begin
        load_mem  = !bus.PCSrc && state_q == REQ && bus.IMemReady && (!valid_q || !bus.Stall);
        skid_load = !bus.PCSrc && state_q == REQ && bus.IMemReady && valid_q && bus.Stall;
        load_skid = !bus.PCSrc && state_q == HOLD && !bus.Stall && skid_valid;
        instr_d   = load_mem ? bus.IMemData : load_skid ? skid_word : instr_q;
        ipc_d     = load_mem ? pc_q : load_skid ? skid_pc : ipc_q;
        valid_d   = load_mem || load_skid || (valid_q && bus.Stall && !bus.PCSrc);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = (state_q == REQ && bus.IMemReady) ? pc_q + PC_STEP : pc_q;
        case (state_q)
            IDLE:    state_d = REQ;
            REQ:     state_d = (bus.IMemReady && valid_q && bus.Stall) ? HOLD : REQ;
            DISCARD: state_d = bus.IMemReady ? REQ : DISCARD;
            HOLD:    state_d = bus.Stall ? HOLD : REQ;
            default: state_d = IDLE;
        endcase
        // Redirect beats stall and data; an unanswered request must still finish in DISCARD.
        if (bus.PCSrc) begin
            pc_d    = bus.BranchTarget & ~32'h3;
            state_d = ((state_q == REQ || state_q == DISCARD) && !bus.IMemReady) ? DISCARD : REQ;
        end
        addr_d = (state_d == REQ) ? pc_d : addr_q;
        req_d  = (state_d == REQ) || (state_d == DISCARD);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC_A;
            addr_q  <= RESET_PC_A;
            req_q   <= 1'b0;
            instr_q <= NOP_INSTR;
            ipc_q   <= RESET_PC_A;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

    assign bus.IMemReq     = req_q;
    assign bus.IMemAddr    = addr_q;
    assign bus.Instruction = instr_q;
    assign bus.InstrPC     = ipc_q;
    assign bus.InstrValid  = valid_q;

`ifdef IFETCH_STATS_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, redir_cnt_q, redir_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'b0, load_mem || load_skid};
        redir_cnt_d = redir_cnt_q + {31'b0, bus.PCSrc};
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            fetch_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign bus.FetchCount    = fetch_cnt_q;
    assign bus.RedirectCount = redir_cnt_q;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed stimulus with a scoreboard of fetched words checked as decode consumes them.
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_if bus();
    instruction_fetch dut (.Clk(clk), .Rst(rst), .bus(bus));

    assign bus.IMemData = bus.IMemAddr ^ 32'hA5A5_0000;

    int          n_chk = 0, n_fail = 0, delivered = 0, n_push = 0, n_redir = 0, d0 = 0;
    logic [31:0] exp_pc = '0, disc_addr = '0;
    logic        discarding = 1'b0, prev_pend = 1'b0;
    logic [63:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic monitor();
        logic [63:0] e;
        if (rst) return;
        if (prev_pend) chk("req_stable", {31'b0, bus.IMemReq}, 32'd1);
        if (bus.IMemReq) chk("imem_addr", bus.IMemAddr, discarding ? disc_addr : exp_pc);
        if (bus.InstrValid && !bus.Stall && !bus.PCSrc) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL sb_underflow: observed live word pc %h, expected none pending", bus.InstrPC);
            end else begin
                e = sb.pop_front();
                chk("instr", bus.Instruction, e[63:32]);
                chk("instr_pc", bus.InstrPC, e[31:0]);
                delivered++;
            end
        end
        if (bus.PCSrc) begin
            if (bus.IMemReq && !bus.IMemReady) begin
                if (!discarding) disc_addr = exp_pc;
                discarding = 1'b1;
            end else discarding = 1'b0;
            exp_pc = bus.BranchTarget & ~32'h3;
            sb.delete();
            n_redir++;
        end else if (bus.IMemReq && bus.IMemReady) begin
            if (discarding) discarding = 1'b0;
            else begin
                sb.push_back({exp_pc ^ 32'hA5A5_0000, exp_pc});
                exp_pc += 32'd4;
                n_push++;
            end
        end
        prev_pend = bus.IMemReq && !bus.IMemReady;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req"}, {31'b0, bus.IMemReq}, 32'd0);
        chk({tag, "_addr"}, bus.IMemAddr, 32'h0);
        chk({tag, "_instr"}, bus.Instruction, 32'h0);
        chk({tag, "_ipc"}, bus.InstrPC, 32'h0);
        chk({tag, "_valid"}, {31'b0, bus.InstrValid}, 32'd0);
`ifdef IFETCH_STATS_EN
        chk({tag, "_fetch_cnt"}, bus.FetchCount, 32'h0);
        chk({tag, "_redir_cnt"}, bus.RedirectCount, 32'h0);
`endif
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.PCSrc = 1'b0;
        bus.Stall = 1'b0;
        bus.IMemReady = 1'b0;
        sb.delete();
        exp_pc = '0;
        discarding = 1'b0;
        prev_pend = 1'b0;
        n_push = 0;
        n_redir = 0;
        tick();
        tick();
        check_reset_vals("reset");
        rst = 1'b0;
        chk("idle_req", {31'b0, bus.IMemReq}, 32'd0);
        tick();
        chk("first_req", {31'b0, bus.IMemReq}, 32'd1);
        chk("first_addr", bus.IMemAddr, 32'h0);
    endtask

    initial begin
        bus.PCSrc = 1'b0;
        bus.BranchTarget = '0;
        bus.Stall = 1'b0;
        bus.IMemReady = 1'b0;
        apply_reset();

        // Streaming with memory always ready
        bus.IMemReady = 1'b1;
        tick();
        chk("first_instr", bus.Instruction, 32'hA5A5_0000);
        chk("first_ipc", bus.InstrPC, 32'h0);
        chk("first_valid", {31'b0, bus.InstrValid}, 32'd1);
        chk("stream_addr", bus.IMemAddr, 32'h4);
        for (int i = 0; i < 5; i++) tick();
        chk("stream_ipc", bus.InstrPC, 32'h14);

        // Memory answers three cycles late
        bus.IMemReady = 1'b0;
        tick();
        d0 = delivered;
        tick();
        tick();
        bus.IMemReady = 1'b1;
        tick();
        bus.IMemReady = 1'b0;
        tick();
        tick();
        chk("one_word", 32'(delivered - d0), 32'd1);
        chk("late_valid", {31'b0, bus.InstrValid}, 32'd0);
`ifdef IFETCH_STATS_EN
        chk("fetch_cnt", bus.FetchCount, 32'(n_push));
`endif

        // Stall with full slot while the word at PC 8 returns
        apply_reset();
        bus.IMemReady = 1'b1;
        tick();
        tick();
        bus.Stall = 1'b1;
        tick();
        chk("hold_req", {31'b0, bus.IMemReq}, 32'd0);
        chk("hold_ipc", bus.InstrPC, 32'h4);
        tick();
        chk("hold_req2", {31'b0, bus.IMemReq}, 32'd0);
        bus.Stall = 1'b0;
        tick();
        chk("skid_ipc", bus.InstrPC, 32'h8);
        chk("skid_instr", bus.Instruction, 32'hA5A5_0008);
        chk("resume_req", {31'b0, bus.IMemReq}, 32'd1);
        chk("resume_addr", bus.IMemAddr, 32'hC);

        // Redirect while a request is outstanding
        bus.IMemReady = 1'b0;
        tick();
        bus.PCSrc = 1'b1;
        bus.BranchTarget = 32'h0000_0043;
        tick();
        bus.PCSrc = 1'b0;
        chk("disc_valid", {31'b0, bus.InstrValid}, 32'd0);
        chk("disc_addr", bus.IMemAddr, 32'hC);
        bus.IMemReady = 1'b1;
        tick();
        chk("redir_addr", bus.IMemAddr, 32'h40);
        chk("redir_valid", {31'b0, bus.InstrValid}, 32'd0);
        tick();
        chk("redir_instr", bus.Instruction, 32'hA5A5_0040);
        chk("redir_ipc", bus.InstrPC, 32'h40);

        // Redirect with memory ready, then PC wrap
        bus.PCSrc = 1'b1;
        bus.BranchTarget = 32'hFFFF_FFF8;
        tick();
        bus.PCSrc = 1'b0;
        chk("fast_redir_addr", bus.IMemAddr, 32'hFFFF_FFF8);
        chk("fast_redir_valid", {31'b0, bus.InstrValid}, 32'd0);
        tick();
        tick();
        chk("wrap_addr", bus.IMemAddr, 32'h0);
        chk("wrap_ipc", bus.InstrPC, 32'hFFFF_FFFC);
        tick();
        chk("wrap_ipc2", bus.InstrPC, 32'h0);
`ifdef IFETCH_STATS_EN
        chk("redir_cnt", bus.RedirectCount, 32'(n_redir));
`endif

        // Asynchronous reset in HOLD
        bus.Stall = 1'b1;
        tick();
        chk("hold2_req", {31'b0, bus.IMemReq}, 32'd0);
        chk("hold2_valid", {31'b0, bus.InstrValid}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        bus.Stall = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
